// File: rtl/apb_master_bridge_pkg.sv
// Shared APB definitions: bridge FSM states, default bus widths and the
// command/response field layouts reused by the register slaves and arbiters.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Packed command = {write, addr, wdata}; packed response = {err, rdata}.
  localparam int APB_CMD_W = 1 + APB_ADDR_W + APB_DATA_W;
  localparam int APB_RSP_W = 1 + APB_DATA_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic                  err;
    logic [APB_DATA_W-1:0] rdata;
  } apb_rsp_t;

  // Bits needed to count up to timeout; a disabled timeout still gets one bit.
  function automatic int wait_cnt_w(input int timeout);
    int w;
    w = 1;
    while ((1 << w) < (timeout + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// master = bridge side, slave = command source / response sink / APB slave side.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  // Valid/ready rule for cmd_* and rsp_*: a transfer happens on a rising edge
  // where valid and ready are both 1; once raised, valid and its payload hold
  // until that edge, and ready never waits on valid from the same channel.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_wait_timer.sv
// ACCESS wait-state counter; expired is high while the count sits at TIMEOUT-1,
// so the next un-ready edge is the one that aborts. TIMEOUT = 0 never expires.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = wait_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command channel to APB SETUP/ACCESS bridge, one transfer in
// flight, with a wait-state timeout so a hung slave still yields a response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  apb_master_bridge_if.master bus,
  output apb_state_e          state_dbg
);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic tmr_clr;
  logic tmr_inc;
  logic tmr_expired;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (pclk),
    .rst     (preset),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          tmr_clr   = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // A completing slave wins over a timeout landing on the same edge.
        if (bus.pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired) begin
            state_d     = RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge (TIMEOUT = 4): directed vector table, reset
// sequences and randomized transfers checked against a transfer-level model.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;      // un-ready ACCESS cycles before pready
    logic          slverr;
    logic [DW-1:0] prdata;
    int            rsp_delay;  // cycles of rsp_ready = 0 in RESP
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_acc;    // ACCESS cycles with psel & penable high
  } vec_t;

  logic       pclk = 1'b0;
  logic       preset;
  apb_state_e state_dbg;

  apb_master_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [DW:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Transfer-level reference: outcome depends only on wait count vs TIMEOUT.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    if (v.waits >= TO) begin
      r.exp_err   = 1'b1;
      r.exp_rdata = '0;
      r.exp_acc   = TO;
    end else begin
      r.exp_err   = v.slverr;
      r.exp_rdata = (v.write || v.slverr) ? '0 : v.prdata;
      r.exp_acc   = v.waits + 1;
    end
    return r;
  endfunction

  // Driver: one full command -> APB -> response transaction, starting in IDLE.
  task automatic do_txn(input vec_t v);
    logic [DW:0] exp;
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    tick();
    // SETUP; cmd_* now scrambled and must be ignored
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = ~v.write;
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    chk("setup_psel", bus.psel, 1);
    chk("setup_penable", bus.penable, 0);
    chk("setup_pwrite", bus.pwrite, v.write);
    chk("setup_paddr", bus.paddr, v.addr);
    chk("setup_pwdata", bus.pwdata, v.wdata);
    chk("setup_cmd_ready", bus.cmd_ready, 0);
    chk("setup_rsp_valid", bus.rsp_valid, 0);
    bus.pready = 1'b0;
    tick();
    for (int i = 0; i < v.exp_acc; i++) begin
      chk("access_psel", bus.psel, 1);
      chk("access_penable", bus.penable, 1);
      chk("access_paddr", bus.paddr, v.addr);
      chk("access_pwrite", bus.pwrite, v.write);
      chk("access_pwdata", bus.pwdata, v.wdata);
      chk("access_rsp_valid", bus.rsp_valid, 0);
      bus.pready  = (i == v.waits);
      bus.prdata  = (i == v.waits) ? v.prdata : DW'($urandom);
      bus.pslverr = (i == v.waits) ? v.slverr : 1'($urandom_range(0, 1));
      tick();
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = $urandom;
    chk("resp_rsp_valid", bus.rsp_valid, 1);
    chk("resp_psel", bus.psel, 0);
    chk("resp_penable", bus.penable, 0);
    chk("resp_cmd_ready", bus.cmd_ready, 0);
    chk("scoreboard_depth", exp_q.size(), 1);
    exp = exp_q.pop_front();
    chk("rsp_err", bus.rsp_err, exp[DW]);
    chk("rsp_rdata", bus.rsp_rdata, exp[DW-1:0]);
    for (int d = 0; d < v.rsp_delay; d++) begin
      bus.rsp_ready = 1'b0;
      bus.cmd_valid = 1'b1;
      tick();
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_err", bus.rsp_err, exp[DW]);
      chk("bp_rsp_rdata", bus.rsp_rdata, exp[DW-1:0]);
      chk("bp_psel", bus.psel, 0);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_cmd_ready", bus.cmd_ready, 1);
    chk("done_state", state_dbg, IDLE);
    chk("done_rsp_err_kept", bus.rsp_err, exp[DW]);
    chk("done_rsp_rdata_kept", bus.rsp_rdata, exp[DW-1:0]);
    chk("done_psel", bus.psel, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_psel"}, bus.psel, 0);
    chk({tag, "_penable"}, bus.penable, 0);
    chk({tag, "_pwrite"}, bus.pwrite, 0);
    chk({tag, "_paddr"}, bus.paddr, 0);
    chk({tag, "_pwdata"}, bus.pwdata, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_state"}, state_dbg, IDLE);
  endtask

  vec_t dir_v[7];
  vec_t rv;

  initial begin
    // write/addr/wdata/waits/slverr/prdata/delay | exp_err/exp_rdata/exp_acc
    dir_v[0] = '{1'b1, 32'h04, 32'hDEADBEEF, 0, 1'b0, 32'hAAAA5555, 0, 1'b0, 32'h0, 1};
    dir_v[1] = '{1'b0, 32'h08, 32'h0, 3, 1'b0, 32'h12345678, 0, 1'b0, 32'h12345678, 4};
    dir_v[2] = '{1'b0, 32'h0C, 32'h0, 0, 1'b1, 32'h0000FFFF, 0, 1'b1, 32'h0, 1};
    dir_v[3] = '{1'b0, 32'h10, 32'h0, 4, 1'b0, 32'h11112222, 2, 1'b1, 32'h0, 4};
    dir_v[4] = '{1'b1, 32'h14, 32'h0BADF00D, 2, 1'b1, 32'h0, 1, 1'b1, 32'h0, 3};
    dir_v[5] = '{1'b0, 32'h18, 32'h0, 0, 1'b0, 32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 1};
    dir_v[6] = '{1'b1, 32'h1C, 32'h55AA55AA, 10, 1'b0, 32'h0, 0, 1'b1, 32'h0, 4};

    preset        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    tick();
    tick();
    chk_reset_state("reset");
    preset = 1'b0;
    tick();

    foreach (dir_v[i]) do_txn(dir_v[i]);

    // Reset during ACCESS drops the transfer with no response.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 32'h76543210;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("mid_access_state", state_dbg, ACCESS);
    chk("mid_access_penable", bus.penable, 1);
    preset = 1'b1;
    tick();
    preset = 1'b0;
    chk_reset_state("mid_reset");
    bus.pready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("post_reset_rsp_valid", bus.rsp_valid, 0);
      chk("post_reset_psel", bus.psel, 0);
    end
    bus.pready = 1'b0;
    chk("post_reset_no_pending", exp_q.size(), 0);

    for (int n = 0; n < 40; n++) begin
      rv.write     = 1'($urandom_range(0, 1));
      rv.addr      = $urandom;
      rv.wdata     = $urandom;
      rv.waits     = int'($urandom_range(0, 6));
      rv.slverr    = ($urandom_range(0, 3) == 0);
      rv.prdata    = $urandom;
      rv.rsp_delay = int'($urandom_range(0, 3));
      do_txn(model(rv));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
